noaa_window_sequencer: RTL
==========================

Name: noaa_window_sequencer

Overview:
- Control FSM for the NOAA averaging/std-dev datapath; register file, numerator/denominator and divider logic sit outside this block.
- Per START it clears the accumulator, collects NSAMP temperature samples, runs one mean pass (MODE=0), then NITER sigma-refinement passes (MODE=1).
- It issues a sigma-load strobe after each refinement and signals DONE.
- A per-calculation watchdog aborts to IDLE with ERR if the datapath never answers.

Parameters:
- NSAMP, 8, samples per window; legal 1..15 (fits the 4-bit N count).
- NITER, 4, sigma-refinement passes; legal 1..15.
- TIMEOUT, 255, max cycles to wait for CALC_DONE after CALC_GO; legal 1..255.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  begin a window; sampled only in IDLE.
- TN_VALID  in  1  new temperature word present on the sensor bus.
- CALC_DONE  in  1  datapath result valid, one-cycle pulse.
- CLEAR  out  1  one-cycle pulse clearing the accumulator (Tsum, N).
- SAMPLE  out  1  one-cycle pulse per accepted sample; register file loads TN.
- MODE  out  1  0 = mean pass, 1 = std-dev pass.
- CALC_GO  out  1  one-cycle pulse starting a datapath calculation.
- SIGMA_LOAD  out  1  one-cycle pulse; datapath loads sigma_hat from AVG_SD.
- ITER  out  4  completed refinement passes in the current window.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when the window completes.
- ERR  out  1  sticky watchdog flag.

Behaviour:
- All outputs are registered. Everything is evaluated on the rising edge of CLK.
- Reset, at any time including mid-operation:
  - Next state is IDLE.
  - All outputs are 0, including ERR and ITER.
  - Sample counter and watchdog counter are 0.
  - A CALC_DONE pending at reset is discarded.
- IDLE:
  - On START=1, go to CLR. CLEAR=1 for exactly the first cycle of CLR. ERR is cleared at this same edge. ITER is set to 0.
  - With START=0, stay in IDLE.
- CLR:
  - Lasts 1 cycle, then goes to COLLECT. The sample counter is 0.
- COLLECT:
  - At each edge with TN_VALID=1: SAMPLE<=1 for one cycle and the counter increments.
  - At an edge with TN_VALID=0: SAMPLE<=0.
  - Back-to-back TN_VALID produces back-to-back SAMPLE pulses.
  - At the edge where the counter reaches NSAMP, go to MEAN. CALC_GO<=1 and MODE<=0 at that same edge.
  - There is no timeout in COLLECT.
- MEAN:
  - CALC_GO is high only in the first cycle. The watchdog counts cycles after CALC_GO.
  - On CALC_DONE=1: go to SD, with MODE<=1 and CALC_GO<=1 at the same edge.
- SD:
  - CALC_GO is high in the first cycle of each pass.
  - On CALC_DONE=1: SIGMA_LOAD<=1 for one cycle and ITER increments.
  - If ITER+1 < NITER, restart SD: CALC_GO<=1 at the same edge and the watchdog is reset.
  - Otherwise go to FIN.
- FIN:
  - DONE=1 for its single cycle, then go to IDLE.
  - MODE holds 1 until the next START and then returns to 0 in CLR.
  - ITER holds its final value until the next START.
- Watchdog (MEAN and SD only):
  - If the counter reaches TIMEOUT without CALC_DONE: ERR<=1, go to IDLE, MODE<=0. No DONE is produced.
  - CALC_DONE on the same edge as expiry wins: it is processed normally and ERR stays 0.
- Ignored inputs:
  - START while BUSY is ignored; no restart, no queueing.
  - TN_VALID outside COLLECT is ignored.
  - CALC_DONE in IDLE, CLR, COLLECT or FIN is ignored.
- Latency:
  - START to first possible SAMPLE is 3 edges (IDLE→CLR→COLLECT, then accept).
  - FIN is 1 cycle after the last CALC_DONE.

Test Plan:
1. Nominal run, NSAMP=8, NITER=4, TN_VALID continuous, CALC_DONE returned 3 cycles after each CALC_GO:
   - One CLEAR pulse, then 8 consecutive SAMPLE pulses.
   - CALC_GO with MODE=0, then 4 CALC_GO with MODE=1.
   - 4 SIGMA_LOAD pulses; ITER ends at 4.
   - DONE pulses once; BUSY falls the cycle after DONE.
2. Gapped samples, TN_VALID high on alternate cycles:
   - Exactly 8 SAMPLE pulses, each aligned to a TN_VALID.
   - MEAN is entered at the edge of the 8th sample; extra TN_VALID after that produces no SAMPLE.
3. Watchdog, TIMEOUT=255, second SD pass never answered:
   - ERR=1 exactly 255 cycles after that CALC_GO; state returns to IDLE; ITER=1; no DONE.
   - The next START clears ERR.
4. Expiry collision, CALC_DONE arrives on the expiry cycle:
   - Run continues; ERR stays 0; DONE is eventually produced.
5. RESET mid-SD (ITER=2):
   - Next cycle all outputs are 0 and state is IDLE.
   - A later CALC_DONE causes no SIGMA_LOAD.
6. START pulsed during COLLECT and SD:
   - No extra CLEAR, and counters are undisturbed.
   - START asserted in the cycle after DONE begins a new window with CLEAR.

Source files
------------

// File: rtl/noaa_window_sequencer.sv
// Control sequencer for the NOAA mean / sigma-refinement datapath.
// Collects NSAMP samples, runs one mean pass then NITER sigma passes, guarded by a per-pass watchdog.
module noaa_window_sequencer #(
  parameter int NSAMP   = 8,
  parameter int NITER   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       TN_VALID,
  input  logic       CALC_DONE,
  output logic       CLEAR,
  output logic       SAMPLE,
  output logic       MODE,
  output logic       CALC_GO,
  output logic       SIGMA_LOAD,
  output logic [3:0] ITER,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam logic [3:0] NSAMP_C   = 4'(NSAMP);
  localparam logic [3:0] NITER_C   = 4'(NITER);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_COLLECT,
    S_MEAN,
    S_SD,
    S_FIN
  } state_t;

  state_t     state, state_n;
  logic [3:0] samp_cnt, samp_cnt_n;
  logic [7:0] wd_cnt, wd_cnt_n;

  logic       clear_n, sample_n, mode_n, go_n, sl_n, busy_n, done_n, err_n;
  logic [3:0] iter_n;

  logic last_sample, wd_expire, more_passes;

  assign last_sample = (samp_cnt + 4'd1) == NSAMP_C;
  assign wd_expire   = (wd_cnt + 8'd1) == TIMEOUT_C;
  assign more_passes = (ITER + 4'd1) < NITER_C;

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      samp_cnt   <= '0;
      wd_cnt     <= '0;
      CLEAR      <= 1'b0;
      SAMPLE     <= 1'b0;
      MODE       <= 1'b0;
      CALC_GO    <= 1'b0;
      SIGMA_LOAD <= 1'b0;
      ITER       <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      state      <= state_n;
      samp_cnt   <= samp_cnt_n;
      wd_cnt     <= wd_cnt_n;
      CLEAR      <= clear_n;
      SAMPLE     <= sample_n;
      MODE       <= mode_n;
      CALC_GO    <= go_n;
      SIGMA_LOAD <= sl_n;
      ITER       <= iter_n;
      BUSY       <= busy_n;
      DONE       <= done_n;
      ERR        <= err_n;
    end
  end

  // Next state; CALC_DONE takes priority over watchdog expiry
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (START) state_n = S_CLR;
      S_CLR:     state_n = S_COLLECT;
      S_COLLECT: if (TN_VALID && last_sample) state_n = S_MEAN;
      S_MEAN: begin
        if (CALC_DONE)      state_n = S_SD;
        else if (wd_expire) state_n = S_IDLE;
      end
      S_SD: begin
        if (CALC_DONE)      state_n = more_passes ? S_SD : S_FIN;
        else if (wd_expire) state_n = S_IDLE;
      end
      S_FIN:     state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and counters
  always_comb begin
    clear_n    = 1'b0;
    sample_n   = 1'b0;
    go_n       = 1'b0;
    sl_n       = 1'b0;
    done_n     = 1'b0;
    mode_n     = MODE;
    iter_n     = ITER;
    err_n      = ERR;
    samp_cnt_n = samp_cnt;
    wd_cnt_n   = wd_cnt;
    busy_n     = (state_n != S_IDLE);
    unique case (state)
      S_IDLE: begin
        if (START) begin
          clear_n    = 1'b1;
          err_n      = 1'b0;
          iter_n     = '0;
          mode_n     = 1'b0;
          samp_cnt_n = '0;
        end
      end
      S_CLR: begin
        samp_cnt_n = '0;
        wd_cnt_n   = '0;
      end
      S_COLLECT: begin
        if (TN_VALID) begin
          sample_n   = 1'b1;
          samp_cnt_n = samp_cnt + 4'd1;
          if (last_sample) begin
            go_n     = 1'b1;
            mode_n   = 1'b0;
            wd_cnt_n = '0;
          end
        end
      end
      S_MEAN: begin
        if (CALC_DONE) begin
          go_n     = 1'b1;
          mode_n   = 1'b1;
          wd_cnt_n = '0;
        end else if (wd_expire) begin
          err_n    = 1'b1;
          mode_n   = 1'b0;
          wd_cnt_n = '0;
        end else begin
          wd_cnt_n = wd_cnt + 8'd1;
        end
      end
      S_SD: begin
        if (CALC_DONE) begin
          sl_n     = 1'b1;
          iter_n   = ITER + 4'd1;
          wd_cnt_n = '0;
          if (more_passes) go_n = 1'b1;
          else             done_n = 1'b1;
        end else if (wd_expire) begin
          err_n    = 1'b1;
          mode_n   = 1'b0;
          wd_cnt_n = '0;
        end else begin
          wd_cnt_n = wd_cnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

endmodule
